// File: rtl/l2_fill_controller_pkg.sv
// Shared definitions for the L2 miss-service path: fill FSM states, default latency
// and the saturating miss-counter helper.
package l2_fill_controller_pkg;

    localparam int unsigned DEFAULT_MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_WAIT = 2'd1,
        FILL_FILL = 2'd2
    } fill_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l2_fill_controller_mem.sv
// Backing main memory: synchronous write port, asynchronous read port that returns
// the word being written on the same edge when the addresses collide.
module main_memory_array #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/l2_fill_controller.sv
// Miss-service stage for l2_cache: waits MEM_LATENCY cycles, then strobes the fetched
// word into the cache for one cycle, suppressing a repeat fill of a stale miss.
module l2_fill_controller
    import l2_fill_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  l2_miss,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  promote_data,
    output logic [DATA_WIDTH-1:0] promotion_data,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  busy,
    output logic [15:0]           miss_count
);

    localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

    fill_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  last_valid_q, last_valid_d;
    logic                  busy_q, busy_d;
    logic                  promote_q, promote_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  stale_hit;

    main_memory_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(fill_addr_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            fill_addr_q  <= '0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            promote_q    <= 1'b0;
            pdata_q      <= '0;
            miss_cnt_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            fill_addr_q  <= fill_addr_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
            busy_q       <= busy_d;
            promote_q    <= promote_d;
            pdata_q      <= pdata_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign stale_hit = last_valid_q && (address == last_addr_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_addr_d  = fill_addr_q;
        last_addr_d  = last_addr_q;
        busy_d       = busy_q;
        promote_d    = promote_q;
        pdata_d      = pdata_q;
        miss_cnt_d   = miss_cnt_q;
        // The cache keeps reporting the miss it just had filled; remember that address
        // only while the requester keeps presenting it with l2_miss high.
        last_valid_d = stale_hit && l2_miss;

        unique case (state_q)
            FILL_IDLE: begin
                if (l2_miss && !stale_hit) begin
                    state_d     = FILL_WAIT;
                    fill_addr_d = address;
                    cnt_d       = CNT_LOAD;
                    busy_d      = 1'b1;
                    miss_cnt_d  = sat_inc16(miss_cnt_q);
                end
            end
            FILL_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    pdata_d   = mem_rdata;
                    promote_d = 1'b1;
                    state_d   = FILL_FILL;
                end
            end
            FILL_FILL: begin
                promote_d    = 1'b0;
                busy_d       = 1'b0;
                last_addr_d  = fill_addr_q;
                last_valid_d = 1'b1;
                state_d      = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    assign promote_data   = promote_q;
    assign promotion_data = pdata_q;
    assign fill_addr      = fill_addr_q;
    assign busy           = busy_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_l2_fill_controller.sv
// Randomized and directed bench for l2_fill_controller: two instances (latency 4 and 1)
// share stimulus and are compared every cycle against a timeline-based reference model.
module tb_l2_fill_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] address;
    logic        l2_miss;
    logic        mem_we;
    logic [10:0] mem_waddr;
    logic [31:0] mem_wdata;

    logic        prom_w  [2];
    logic [31:0] pdata_w [2];
    logic [10:0] faddr_w [2];
    logic        busy_w  [2];
    logic [15:0] mcnt_w  [2];

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    always #5 clk = ~clk;

    l2_fill_controller #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_LATENCY(4)) u0 (
        .clk(clk), .rst(rst), .address(address), .l2_miss(l2_miss),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .promote_data(prom_w[0]), .promotion_data(pdata_w[0]), .fill_addr(faddr_w[0]),
        .busy(busy_w[0]), .miss_count(mcnt_w[0])
    );

    l2_fill_controller #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .address(address), .l2_miss(l2_miss),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .promote_data(prom_w[1]), .promotion_data(pdata_w[1]), .fill_addr(faddr_w[1]),
        .busy(busy_w[1]), .miss_count(mcnt_w[1])
    );

    // Reference model: a fill is described by its trigger edge; busy/promote/data follow
    // from the edge offset relative to that trigger.
    int          edge_no = 0;
    int          lat [2] = '{4, 1};
    logic [31:0] m_mem [2048];
    bit          m_busy [2];
    bit          m_prom [2];
    bit          m_lv   [2];
    int          m_trig [2];
    logic [10:0] m_faddr [2];
    logic [10:0] m_la    [2];
    logic [31:0] m_pd    [2];
    int unsigned m_cnt   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit lv_n;
            if (rst) begin
                m_busy[k]  = 1'b0;
                m_prom[k]  = 1'b0;
                m_lv[k]    = 1'b0;
                m_faddr[k] = '0;
                m_la[k]    = '0;
                m_pd[k]    = '0;
                m_cnt[k]   = 0;
            end else begin
                lv_n = m_lv[k] && l2_miss && (address == m_la[k]);
                if (m_busy[k]) begin
                    if (edge_no - m_trig[k] == lat[k]) begin
                        m_prom[k] = 1'b1;
                        m_pd[k]   = (mem_we && mem_waddr == m_faddr[k]) ? mem_wdata
                                                                        : m_mem[m_faddr[k]];
                    end else if (edge_no - m_trig[k] == lat[k] + 1) begin
                        m_prom[k] = 1'b0;
                        m_busy[k] = 1'b0;
                        m_la[k]   = m_faddr[k];
                        lv_n      = 1'b1;
                    end
                end else if (l2_miss && !(m_lv[k] && address == m_la[k])) begin
                    m_trig[k]  = edge_no;
                    m_busy[k]  = 1'b1;
                    m_faddr[k] = address;
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                end
                m_lv[k] = lv_n;
            end
        end
        if (mem_we) m_mem[mem_waddr] = mem_wdata;
        edge_no++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy[%0d]", k),  32'(busy_w[k]),  32'(m_busy[k]));
            check($sformatf("prom[%0d]", k),  32'(prom_w[k]),  32'(m_prom[k]));
            check($sformatf("pdata[%0d]", k), pdata_w[k],      m_pd[k]);
            check($sformatf("faddr[%0d]", k), 32'(faddr_w[k]), 32'(m_faddr[k]));
            check($sformatf("mcnt[%0d]", k),  32'(mcnt_w[k]),  m_cnt[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] old_word;
        rst = 1'b1; address = '0; l2_miss = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

        // Preload every word so no read ever sees uninitialised storage.
        for (int a = 0; a < 2048; a++) begin
            mem_we    = 1'b1;
            mem_waddr = 11'(a);
            mem_wdata = (a == 'h123) ? 32'hDEADBEEF : $urandom;
            cycle();
        end
        mem_we = 1'b0;

        // Reset held with a miss pending.
        l2_miss = 1'b1; address = 11'h123;
        repeat (2) begin
            cycle();
            check("rst_busy", 32'(busy_w[0]), 32'd0);
            check("rst_prom", 32'(prom_w[0]), 32'd0);
            check("rst_mcnt", 32'(mcnt_w[0]), 32'd0);
        end
        rst = 1'b0; l2_miss = 1'b0;
        cycle();
        check("post_rst_busy", 32'(busy_w[0]), 32'd0);

        // Basic fill, latency 4.
        address = 11'h123; l2_miss = 1'b1;
        cycle();
        check("basic_busy_n", 32'(busy_w[0]), 32'd1);
        check("basic_mcnt", 32'(mcnt_w[0]), 32'd1);
        repeat (3) begin
            cycle();
            check("basic_prom_early", 32'(prom_w[0]), 32'd0);
        end
        cycle();
        check("basic_prom", 32'(prom_w[0]), 32'd1);
        check("basic_data", pdata_w[0], 32'hDEADBEEF);
        check("basic_busy_n4", 32'(busy_w[0]), 32'd1);
        cycle();
        check("basic_busy_end", 32'(busy_w[0]), 32'd0);
        check("basic_prom_end", 32'(prom_w[0]), 32'd0);

        // Stale miss held for 20 cycles.
        repeat (20) cycle();
        check("stale_mcnt", 32'(mcnt_w[0]), 32'd1);
        address = 11'h124;
        cycle();
        check("new_addr_busy", 32'(busy_w[0]), 32'd1);
        check("new_addr_mcnt", 32'(mcnt_w[0]), 32'd2);
        repeat (5) cycle();
        l2_miss = 1'b0;
        cycle();

        // Same-edge forwarding on the read edge.
        address = 11'h200; l2_miss = 1'b1;
        cycle();
        repeat (3) cycle();
        mem_we = 1'b1; mem_waddr = 11'h200; mem_wdata = 32'hCAFE0001;
        cycle();
        mem_we = 1'b0;
        check("fwd_prom", 32'(prom_w[0]), 32'd1);
        check("fwd_data", pdata_w[0], 32'hCAFE0001);
        cycle();

        // Write one edge after the read: old data promoted, memory updated.
        address = 11'h201;
        old_word = m_mem[11'h201];
        cycle();
        repeat (3) cycle();
        cycle();
        check("late_wr_old", pdata_w[0], old_word);
        mem_we = 1'b1; mem_waddr = 11'h201; mem_wdata = 32'hCAFE0001;
        cycle();
        mem_we = 1'b0; l2_miss = 1'b0;
        cycle();
        l2_miss = 1'b1;
        cycle();
        repeat (4) cycle();
        check("late_wr_new", pdata_w[0], 32'hCAFE0001);
        cycle();
        l2_miss = 1'b0;
        cycle();

        // Reset in the middle of WAIT, then a clean restart.
        address = 11'h300; l2_miss = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_busy", 32'(busy_w[0]), 32'd0);
        check("midrst_mcnt", 32'(mcnt_w[0]), 32'd0);
        cycle();
        check("restart_busy", 32'(busy_w[0]), 32'd1);
        repeat (3) begin
            cycle();
            check("restart_prom_early", 32'(prom_w[0]), 32'd0);
        end
        cycle();
        check("restart_prom", 32'(prom_w[0]), 32'd1);
        check("restart_data", pdata_w[0], m_mem[11'h300]);
        cycle();
        l2_miss = 1'b0;
        cycle();

        // Latency 1: back-to-back fills on distinct addresses.
        address = 11'h040; l2_miss = 1'b1;
        cycle();
        check("l1_busy_a", 32'(busy_w[1]), 32'd1);
        check("l1_prom_a0", 32'(prom_w[1]), 32'd0);
        cycle();
        check("l1_prom_a1", 32'(prom_w[1]), 32'd1);
        check("l1_busy_a1", 32'(busy_w[1]), 32'd1);
        address = 11'h041;
        cycle();
        check("l1_busy_a2", 32'(busy_w[1]), 32'd0);
        cycle();
        check("l1_busy_b", 32'(busy_w[1]), 32'd1);
        cycle();
        check("l1_prom_b", 32'(prom_w[1]), 32'd1);
        check("l1_data_b", pdata_w[1], m_mem[11'h041]);
        l2_miss = 1'b0;
        cycle();
        cycle();

        // Saturation: jump the latency-1 counter near its ceiling, then keep filling.
        force u1.miss_cnt_q = 16'hFFFE;
        #1;
        release u1.miss_cnt_q;
        m_cnt[1] = 65534;
        for (int i = 0; i < 4; i++) begin
            address = 11'(11'h042 + (i % 2));
            l2_miss = 1'b1;
            repeat (3) cycle();
        end
        check("sat_mcnt", 32'(mcnt_w[1]), 32'h0000FFFF);
        l2_miss = 1'b0;
        cycle();

        // Random traffic over a small address window.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            l2_miss = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) address = 11'(16 + $urandom_range(0, 3));
            mem_we    = ($urandom_range(0, 3) == 0);
            mem_waddr = 11'(16 + $urandom_range(0, 3));
            mem_wdata = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
